// File: rtl/fejkon_pcie_pkg.sv
// fejkon_pcie_pkg: request/response word layouts and FSM states shared by the PCIe TLP stage and the memory access master
package fejkon_pcie_pkg;

    typedef struct packed {
        logic [2:0]  rsvd;
        logic        is_write;
        logic [3:0]  be;
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [31:0] wdata;
        logic [63:0] addr;
    } mem_access_req_t;

    typedef struct packed {
        logic [59:0] zero;
        logic [3:0]  be;
        logic        err;
        logic [6:0]  lower_addr;
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [31:0] data;
    } mem_access_resp_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} mem_access_state_t;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/fejkon_mem_access_timer.sv
// fejkon_mem_access_timer: loadable down-counter that flags expiry when it reaches zero
module fejkon_mem_access_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    assign expired = count == '0;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else
            count <= load ? load_value : expired ? count : count - 1'b1;
    end

endmodule

// File: rtl/fejkon_pcie_mem_access.sv
// fejkon_pcie_mem_access: single-dword Avalon-MM master for BAR0 accesses; optional read timeout under FEJKON_MEM_ACCESS_TIMEOUT_EN
module fejkon_pcie_mem_access #(
    parameter int ADDR_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] mem_access_req_data,
    input  logic         mem_access_req_valid,
    output logic         mem_access_req_ready,
    output logic [127:0] mem_access_resp_data,
    output logic         mem_access_resp_valid,
    input  logic         mem_access_resp_ready,
    output logic [31:0]  avm_address,
    output logic         avm_read,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    output logic [3:0]   avm_byteenable,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_readdatavalid,
    input  logic [1:0]   avm_response
);

    import fejkon_pcie_pkg::*;

    mem_access_req_t   req;
    mem_access_resp_t  rsp;
    mem_access_state_t state, state_next;
    logic              acc, oor, timed_out;

    assign req                   = mem_access_req_t'(mem_access_req_data);
    assign acc                   = mem_access_req_valid && mem_access_req_ready;
    assign oor                   = (req.addr >> ADDR_BITS) != 64'd0;
    assign mem_access_resp_data  = rsp;
    assign mem_access_resp_valid = state == RESP;

`ifdef FEJKON_MEM_ACCESS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic expired;

    fejkon_mem_access_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (state == ISSUE && !avm_waitrequest && avm_read),
        .load_value (TW'(TIMEOUT_CYCLES - 1)),
        .expired    (expired)
    );

    assign timed_out = expired && state == WAIT_RD;
`else
    assign timed_out = 1'b0;
`endif

    // Next-state: out-of-range writes are dropped, out-of-range reads answer immediately
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc) state_next = !oor ? ISSUE : req.is_write ? IDLE : RESP;
            ISSUE:   if (!avm_waitrequest) state_next = avm_write ? IDLE : WAIT_RD;
            WAIT_RD: if (avm_readdatavalid || timed_out) state_next = RESP;
            RESP:    if (mem_access_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, registered bus strobes and the response word; the response starts as an error and a good read overwrites it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            mem_access_req_ready <= 1'b0;
            avm_address          <= '0;
            avm_read             <= 1'b0;
            avm_write            <= 1'b0;
            avm_writedata        <= '0;
            avm_byteenable       <= '0;
            rsp                  <= '0;
        end else begin
            state                <= state_next;
            mem_access_req_ready <= state_next == IDLE;
            if (acc) begin
                avm_address    <= {req.addr[31:2], 2'b00};
                avm_writedata  <= req.wdata;
                avm_byteenable <= req.be;
                avm_read       <= !oor && !req.is_write;
                avm_write      <= !oor && req.is_write;
                rsp.be         <= req.be;
                rsp.err        <= 1'b1;
                rsp.lower_addr <= req.addr[6:0];
                rsp.tag        <= req.tag;
                rsp.req_id     <= req.req_id;
                rsp.data       <= ERR_DATA;
            end
            if (state == ISSUE && !avm_waitrequest) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
            if (state == WAIT_RD && avm_readdatavalid) begin
                rsp.err  <= avm_response != 2'b00;
                rsp.data <= avm_response != 2'b00 ? ERR_DATA : avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_fejkon_pcie_mem_access.sv
// tb_fejkon_pcie_mem_access: directed self-checking bench for fejkon_pcie_mem_access (timeout case under FEJKON_MEM_ACCESS_TIMEOUT_EN)
module tb_fejkon_pcie_mem_access;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] req_data;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] resp_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [3:0]   avm_byteenable;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic [1:0]   avm_response;

    int checks = 0;
    int errors = 0;

    fejkon_pcie_mem_access #(.ADDR_BITS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .mem_access_req_data   (req_data),
        .mem_access_req_valid  (req_valid),
        .mem_access_req_ready  (req_ready),
        .mem_access_resp_data  (resp_data),
        .mem_access_resp_valid (resp_valid),
        .mem_access_resp_ready (resp_ready),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_write             (avm_write),
        .avm_writedata         (avm_writedata),
        .avm_byteenable        (avm_byteenable),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid),
        .avm_response          (avm_response)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] addr, input logic [31:0] wd, input logic [15:0] id,
                        input logic [7:0] tag, input logic [3:0] be, input logic w);
        req_data  = {3'b000, w, be, tag, id, wd, addr};
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    function automatic logic [199:0] all_outs();
        return {req_ready, resp_valid, resp_data, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable};
    endfunction

    function automatic logic [69:0] bus();
        return {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
    endfunction

    initial begin
        reset_n           = 1'b0;
        req_data          = '0;
        req_valid         = 1'b0;
        resp_ready        = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
        step();
        step();
        check("reset_outputs", all_outs(), 200'd0);
        reset_n = 1'b1;
        step();
        check("ready_after_reset", req_ready, 1'b1);

        send(64'h10, 32'h0, 16'hABCD, 8'h05, 4'hF, 1'b0);
        avm_waitrequest = 1'b1;
        check("rd_strobe_t1", bus(), {1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
        check("rd_ready_low", req_ready, 1'b0);
        step();
        check("rd_strobe_held", bus(), {1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
        step();
        avm_waitrequest = 1'b0;
        check("rd_strobe_held2", bus(), {1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
        step();
        check("rd_strobe_drop", avm_read, 1'b0);
        step();
        step();
        check("rd_no_resp_yet", resp_valid, 1'b0);
        avm_readdata      = 32'hCAFEF00D;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check("rd_resp_valid", resp_valid, 1'b1);
        check("rd_resp_data", resp_data, {60'h0, 4'hF, 1'b0, 7'h10, 8'h05, 16'hABCD, 32'hCAFEF00D});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("rd_done", {resp_valid, req_ready}, 2'b01);

        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check("rdv_idle_ignored", {resp_valid, req_ready}, 2'b01);

        avm_waitrequest = 1'b1;
        send(64'h24, 32'h12345678, 16'h0001, 8'h09, 4'h3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("wr_strobe_held", bus(), {1'b0, 1'b1, 32'h24, 32'h12345678, 4'h3});
            step();
        end
        avm_waitrequest = 1'b0;
        check("wr_strobe_5th", bus(), {1'b0, 1'b1, 32'h24, 32'h12345678, 4'h3});
        step();
        check("wr_done", {avm_write, resp_valid, req_ready}, 3'b001);

        send(64'h1_0000, 32'h0, 16'h2222, 8'h11, 4'hF, 1'b0);
        check("oor_rd_no_strobe", {avm_read, avm_write}, 2'b00);
        check("oor_rd_resp", {resp_valid, resp_data},
              {1'b1, 60'h0, 4'hF, 1'b1, 7'h00, 8'h11, 16'h2222, 32'hFFFFFFFF});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("oor_rd_done", {resp_valid, req_ready}, 2'b01);

        send(64'h2_0004, 32'h55AA55AA, 16'h3333, 8'h12, 4'hF, 1'b1);
        check("oor_wr_dropped", {avm_write, resp_valid, req_ready}, 3'b001);

        send(64'h40, 32'h0, 16'h4444, 8'h21, 4'hC, 1'b0);
        step();
        avm_readdata      = 32'h11111111;
        avm_response      = 2'b10;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
        check("slverr_resp", {resp_valid, resp_data},
              {1'b1, 60'h0, 4'hC, 1'b1, 7'h40, 8'h21, 16'h4444, 32'hFFFFFFFF});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

`ifdef FEJKON_MEM_ACCESS_TIMEOUT_EN
        send(64'h44, 32'h0, 16'h5555, 8'h31, 4'hF, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_waiting", resp_valid, 1'b0);
        end
        step();
        check("to_resp", {resp_valid, resp_data},
              {1'b1, 60'h0, 4'hF, 1'b1, 7'h44, 8'h31, 16'h5555, 32'hFFFFFFFF});
        resp_ready = 1'b1;
        step();
        resp_ready        = 1'b0;
        avm_readdata      = 32'h77777777;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check("to_late_rdv", {resp_valid, req_ready}, 2'b01);
`endif

        send(64'h08, 32'h0, 16'h1234, 8'h33, 4'hF, 1'b0);
        step();
        avm_readdata      = 32'hDEADBEEF;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            avm_readdata      = 32'h0 + i;
            avm_readdatavalid = i[0];
            check("bp_stable", {resp_valid, resp_data},
                  {1'b1, 60'h0, 4'hF, 1'b0, 7'h08, 8'h33, 16'h1234, 32'hDEADBEEF});
            step();
        end
        avm_readdatavalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_in_resp", all_outs(), 200'd0);
        reset_n = 1'b1;
        step();
        check("ready_after_rst2", req_ready, 1'b1);

        send(64'h0C, 32'h0, 16'h6666, 8'h44, 4'hF, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        check("rst_in_wait_rd", all_outs(), 200'd0);
        reset_n           = 1'b1;
        avm_readdata      = 32'h99999999;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check("abandoned_no_resp", {resp_valid, req_ready}, 2'b01);

        send(64'h4C, 32'h0, 16'h7777, 8'h77, 4'hF, 1'b0);
        check("post_rst_strobe", bus(), {1'b1, 1'b0, 32'h4C, 32'h0, 4'hF});
        step();
        avm_readdata      = 32'h0BADCAFE;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check("post_rst_resp", {resp_valid, resp_data},
              {1'b1, 60'h0, 4'hF, 1'b0, 7'h4C, 8'h77, 16'h7777, 32'h0BADCAFE});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("post_rst_done", {resp_valid, req_ready}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
